// File: rtl/cpu7_lsu.sv
// cpu7_lsu: MEM-stage load/store unit acting as a handshaked bus master.
// Generates byte-lane strobes, aligns and extends load data, stalls the
// pipeline across wait states and reports misalign / bus-error exceptions.
//
// state | meaning
// IDLE  | waiting for a MEM-stage request; alignment checked on accept
// BUSY  | bus transfer in flight (cancel flag set if flushed meanwhile)
// RESP  | one-cycle completion: doneM, optional bus-error exception
// FAULT | one-cycle completion of a misaligned access, no bus activity
module cpu7_lsu #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                reqM,
  input  logic                memwriteM,
  input  logic [1:0]          lswidthM,
  input  logic                loadsignextM,
  input  logic [ADDR_W-1:0]   addrM,
  input  logic [XLEN-1:0]     wdataM,
  input  logic                flushM,
  output logic                stallM,
  output logic                doneM,
  output logic [XLEN-1:0]     rdataM,
  output logic                excp_misalignM,
  output logic                excp_buserrM,
  output logic [ADDR_W-1:0]   excp_addrM,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [XLEN/8-1:0]   bus_be,
  output logic [XLEN-1:0]     bus_wdata,
  input  logic                bus_ack,
  input  logic                bus_err,
  input  logic [XLEN-1:0]     bus_rdata
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, FAULT} state_t;

  state_t            state;
  logic              cancel;
  logic [CNT_W-1:0]  cnt;
  logic              err_q;
  logic [XLEN-1:0]   rdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [OFF_W-1:0]  off_q;
  logic [1:0]        width_q;
  logic              sext_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [NB-1:0]     bus_be_q;
  logic [XLEN-1:0]   bus_wdata_q;

  // Byte-lane mask of an access of the given width, right-justified.
  function automatic logic [NB-1:0] size_be(input logic [1:0] w);
    case (w)
      2'b00:   size_be = NB'(1);
      2'b01:   size_be = NB'(3);
      2'b10:   size_be = NB'(8'h0F);
      default: size_be = NB'(8'hFF);
    endcase
  endfunction

  // Expand a byte-lane mask into a bit mask.
  function automatic logic [XLEN-1:0] be_to_bits(input logic [NB-1:0] be);
    for (int i = 0; i < NB; i++) be_to_bits[8*i +: 8] = {8{be[i]}};
  endfunction

  logic              misalign;
  logic [OFF_W-1:0]  off;
  logic [NB-1:0]     be_sh;
  logic [XLEN-1:0]   wdata_sh;
  logic [ADDR_W-1:0] addr_al;
  logic [XLEN-1:0]   rsh;
  logic [XLEN-1:0]   lmask;
  logic              sbit;
  logic [XLEN-1:0]   load_val;
  logic              timeout;
  logic              bus_fail;
  logic              bus_done;

  assign off      = addrM[OFF_W-1:0];
  assign be_sh    = size_be(lswidthM) << off;
  assign wdata_sh = (wdataM & be_to_bits(size_be(lswidthM))) << {off, 3'b000};
  assign addr_al  = {addrM[ADDR_W-1:OFF_W], OFF_W'(0)};

  // Alignment check of the incoming request; doubleword is illegal on a 32-bit bus.
  always_comb begin
    misalign = 1'b0;
    case (lswidthM)
      2'b01:   misalign = addrM[0];
      2'b10:   misalign = |addrM[1:0];
      2'b11:   misalign = (XLEN == 32) || (|addrM[2:0]);
      default: misalign = 1'b0;
    endcase
  end

  assign rsh   = bus_rdata >> {off_q, 3'b000};
  assign lmask = be_to_bits(size_be(width_q));

  // Sign bit of the loaded item, chosen by the registered access width.
  always_comb begin
    sbit = 1'b0;
    case (width_q)
      2'b00:   sbit = rsh[7];
      2'b01:   sbit = rsh[15];
      2'b10:   sbit = rsh[31];
      default: sbit = rsh[XLEN-1];
    endcase
  end

  assign load_val = (rsh & lmask) | ((sext_q && sbit) ? ~lmask : '0);

  assign timeout  = (MAX_WAIT != 0) && (cnt == CNT_W'(MAX_WAIT)) && !bus_ack;
  assign bus_fail = bus_err || timeout;
  assign bus_done = bus_ack || bus_fail;

  // Main controller: accept/check, run the bus transfer, capture the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cancel      <= 1'b0;
      cnt         <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      addr_q      <= '0;
      off_q       <= '0;
      width_q     <= 2'b00;
      sext_q      <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (reqM && !flushM) begin
            addr_q <= addrM;
            err_q  <= 1'b0;
            if (misalign) begin
              state   <= FAULT;
              rdata_q <= '0;
            end else begin
              state       <= BUSY;
              cancel      <= 1'b0;
              cnt         <= '0;
              off_q       <= off;
              width_q     <= lswidthM;
              sext_q      <= loadsignextM;
              bus_we_q    <= memwriteM;
              bus_addr_q  <= addr_al;
              bus_be_q    <= be_sh;
              bus_wdata_q <= wdata_sh;
            end
          end
        end
        BUSY: begin
          if (flushM) cancel <= 1'b1;
          if (bus_done) begin
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            if (cancel || flushM) begin
              // Flushed instruction: transfer finished, result dropped silently.
              state  <= IDLE;
              cancel <= 1'b0;
            end else begin
              state   <= RESP;
              err_q   <= bus_fail;
              rdata_q <= (bus_fail || bus_we_q) ? '0 : load_val;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign doneM          = ((state == RESP) || (state == FAULT)) && !flushM;
  assign excp_misalignM = (state == FAULT) && !flushM;
  assign excp_buserrM   = (state == RESP) && err_q && !flushM;
  assign excp_addrM     = (excp_misalignM || excp_buserrM) ? addr_q : '0;
  assign rdataM         = doneM ? rdata_q : '0;
  assign stallM         = reqM && !flushM && !doneM;

  assign bus_req   = (state == BUSY);
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_cpu7_lsu.sv
// Testbench for cpu7_lsu: a 32-bit instance (MAX_WAIT=4) driven through
// directed steps with a completion scoreboard, plus a 64-bit instance.
module tb_cpu7_lsu;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        a_req, a_we, a_sx, a_flush;
  logic [1:0]  a_w;
  logic [31:0] a_addr, a_wd;
  logic        a_stall, a_done, a_mis, a_exb;
  logic [31:0] a_rd, a_ea;
  logic        a_breq, a_bwe;
  logic [31:0] a_baddr, a_bwd, a_brd;
  logic [3:0]  a_bbe;
  logic        a_back, a_berr;

  // 64-bit instance signals
  logic        d_req, d_we, d_sx, d_flush;
  logic [1:0]  d_w;
  logic [31:0] d_addr;
  logic [63:0] d_wd;
  logic        d_stall, d_done, d_mis, d_exb;
  logic [63:0] d_rd;
  logic [31:0] d_ea;
  logic        d_breq, d_bwe;
  logic [31:0] d_baddr;
  logic [63:0] d_bwd, d_brd;
  logic [7:0]  d_bbe;
  logic        d_back, d_berr;

  cpu7_lsu #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(4)) u32 (
    .clk(clk), .reset(reset), .reqM(a_req), .memwriteM(a_we), .lswidthM(a_w),
    .loadsignextM(a_sx), .addrM(a_addr), .wdataM(a_wd), .flushM(a_flush),
    .stallM(a_stall), .doneM(a_done), .rdataM(a_rd), .excp_misalignM(a_mis),
    .excp_buserrM(a_exb), .excp_addrM(a_ea), .bus_req(a_breq), .bus_we(a_bwe),
    .bus_addr(a_baddr), .bus_be(a_bbe), .bus_wdata(a_bwd), .bus_ack(a_back),
    .bus_err(a_berr), .bus_rdata(a_brd)
  );

  cpu7_lsu #(.XLEN(64), .ADDR_W(32), .MAX_WAIT(15)) u64 (
    .clk(clk), .reset(reset), .reqM(d_req), .memwriteM(d_we), .lswidthM(d_w),
    .loadsignextM(d_sx), .addrM(d_addr), .wdataM(d_wd), .flushM(d_flush),
    .stallM(d_stall), .doneM(d_done), .rdataM(d_rd), .excp_misalignM(d_mis),
    .excp_buserrM(d_exb), .excp_addrM(d_ea), .bus_req(d_breq), .bus_we(d_bwe),
    .bus_addr(d_baddr), .bus_be(d_bbe), .bus_wdata(d_bwd), .bus_ack(d_back),
    .bus_err(d_berr), .bus_rdata(d_brd)
  );

  typedef struct {
    logic [63:0] rd;
    logic        mis;
    logic        berr;
    logic [31:0] ea;
    logic        chk_ea;
  } exp_t;

  exp_t sb32[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push32(input logic [31:0] rd, input logic mis, input logic berr,
                        input logic [31:0] ea, input logic chk_ea);
    exp_t e;
    e.rd = 64'(rd); e.mis = mis; e.berr = berr; e.ea = ea; e.chk_ea = chk_ea;
    sb32.push_back(e);
  endtask

  // Completion monitor: every doneM pulse of the 32-bit unit is matched against the scoreboard.
  always @(negedge clk) begin
    if (reset && a_done) begin
      if (sb32.size() == 0) begin
        check("done_unexpected", 64'(a_done), 64'(0));
      end else begin
        mon_e = sb32.pop_front();
        check("sb_rdata", 64'(a_rd), mon_e.rd);
        check("sb_misalign", 64'(a_mis), 64'(mon_e.mis));
        check("sb_buserr", 64'(a_exb), 64'(mon_e.berr));
        if (mon_e.chk_ea) check("sb_excp_addr", 64'(a_ea), 64'(mon_e.ea));
      end
    end
  end

  // One aligned access on the 32-bit unit; ack (and optional err) after k extra BUSY cycles.
  task automatic access32(input string tag, input logic wr, input logic [1:0] wi, input logic sxt,
                          input logic [31:0] ad, input logic [31:0] wdat, input logic [31:0] rdat,
                          input int k, input logic ber, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd, input logic [31:0] exp_rd);
    push32(exp_rd, 1'b0, ber, ad, ber);
    a_req = 1'b1; a_we = wr; a_w = wi; a_sx = sxt; a_addr = ad; a_wd = wdat;
    #1;
    check({tag, "_stall_accept"}, 64'(a_stall), 64'(1));
    tick();
    check({tag, "_bus_req"}, 64'(a_breq), 64'(1));
    check({tag, "_bus_addr"}, 64'(a_baddr), 64'(ad & ~32'h3));
    check({tag, "_bus_be"}, 64'(a_bbe), 64'(exp_be));
    check({tag, "_bus_we"}, 64'(a_bwe), 64'(wr));
    if (wr) check({tag, "_bus_wdata"}, 64'(a_bwd), 64'(exp_wd));
    for (int i = 0; i < k; i++) begin
      tick();
      check({tag, "_stall_wait"}, 64'(a_stall), 64'(1));
    end
    a_back = 1'b1; a_berr = ber; a_brd = rdat;
    tick();
    a_back = 1'b0; a_berr = 1'b0;
    check({tag, "_done"}, 64'(a_done), 64'(1));
    check({tag, "_stall_resp"}, 64'(a_stall), 64'(0));
    a_req = 1'b0;
    tick();
    check({tag, "_done_pulse"}, 64'(a_done), 64'(0));
    check({tag, "_bus_req_idle"}, 64'(a_breq), 64'(0));
  endtask

  // Misaligned / illegal-width access: FAULT one cycle after accept, no bus request.
  task automatic misalign32(input string tag, input logic [1:0] wi, input logic [31:0] ad);
    push32(32'h0, 1'b1, 1'b0, ad, 1'b1);
    a_req = 1'b1; a_we = 1'b0; a_w = wi; a_addr = ad;
    #1;
    check({tag, "_stall_accept"}, 64'(a_stall), 64'(1));
    tick();
    check({tag, "_bus_req"}, 64'(a_breq), 64'(0));
    check({tag, "_done"}, 64'(a_done), 64'(1));
    check({tag, "_misalign"}, 64'(a_mis), 64'(1));
    a_req = 1'b0;
    tick();
    check({tag, "_done_pulse"}, 64'(a_done), 64'(0));
  endtask

  // One load on the 64-bit unit with immediate ack.
  task automatic load64(input string tag, input logic [1:0] wi, input logic sxt,
                        input logic [31:0] ad, input logic [63:0] rdat,
                        input logic [31:0] exp_addr, input logic [7:0] exp_be,
                        input logic [63:0] exp_rd);
    d_req = 1'b1; d_we = 1'b0; d_w = wi; d_sx = sxt; d_addr = ad;
    tick();
    check({tag, "_bus_addr"}, 64'(d_baddr), 64'(exp_addr));
    check({tag, "_bus_be"}, 64'(d_bbe), 64'(exp_be));
    d_back = 1'b1; d_brd = rdat;
    tick();
    d_back = 1'b0;
    check({tag, "_done"}, 64'(d_done), 64'(1));
    check({tag, "_rdata"}, d_rd, exp_rd);
    d_req = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b0;
    a_req = 0; a_we = 0; a_sx = 0; a_flush = 0; a_w = 0; a_addr = 0; a_wd = 0;
    a_back = 0; a_berr = 0; a_brd = 0;
    d_req = 0; d_we = 0; d_sx = 0; d_flush = 0; d_w = 0; d_addr = 0; d_wd = 0;
    d_back = 0; d_berr = 0; d_brd = 0;
    repeat (2) tick();

    check("rst_stall", 64'(a_stall), 64'(0));
    check("rst_done", 64'(a_done), 64'(0));
    check("rst_rdata", 64'(a_rd), 64'(0));
    check("rst_misalign", 64'(a_mis), 64'(0));
    check("rst_buserr", 64'(a_exb), 64'(0));
    check("rst_excp_addr", 64'(a_ea), 64'(0));
    check("rst_bus_req", 64'(a_breq), 64'(0));
    check("rst_bus_we", 64'(a_bwe), 64'(0));
    check("rst_bus_addr", 64'(a_baddr), 64'(0));
    check("rst_bus_be", 64'(a_bbe), 64'(0));
    check("rst_bus_wdata", 64'(a_bwd), 64'(0));
    check("rst64_bus_req", 64'(d_breq), 64'(0));

    reset = 1'b1;
    tick();

    // Loads and a store on the 32-bit unit
    access32("lw",  1'b0, 2'b10, 1'b0, 32'h1004, 32'h0, 32'hDEADBEEF, 2, 1'b0, 4'hF, 32'h0, 32'hDEADBEEF);
    access32("lb",  1'b0, 2'b00, 1'b1, 32'h2003, 32'h0, 32'h80112233, 0, 1'b0, 4'h8, 32'h0, 32'hFFFFFF80);
    access32("lbu", 1'b0, 2'b00, 1'b0, 32'h2003, 32'h0, 32'h80112233, 1, 1'b0, 4'h8, 32'h0, 32'h00000080);
    access32("lh",  1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 32'h80112233, 0, 1'b0, 4'hC, 32'h0, 32'hFFFF8011);
    access32("sh",  1'b1, 2'b01, 1'b0, 32'h3002, 32'h1234ABCD, 32'hFFFFFFFF, 0, 1'b0, 4'hC, 32'hABCD0000, 32'h0);

    // Misaligned word and doubleword on a 32-bit bus
    misalign32("lw_mis", 2'b10, 32'h1002);
    misalign32("ld_32", 2'b11, 32'h1000);

    // Flush while in FAULT suppresses done and the exception
    a_req = 1'b1; a_w = 2'b01; a_addr = 32'h2001;
    tick();
    a_flush = 1'b1;
    #1;
    check("fault_flush_done", 64'(a_done), 64'(0));
    check("fault_flush_mis", 64'(a_mis), 64'(0));
    a_req = 1'b0;
    tick();
    a_flush = 1'b0;

    // Timeout: no ack, bus_req high MAX_WAIT+1 cycles
    push32(32'h0, 1'b0, 1'b1, 32'h4000, 1'b1);
    a_req = 1'b1; a_we = 1'b0; a_w = 2'b10; a_addr = 32'h4000;
    tick();
    n = 0;
    for (int i = 0; i < 20 && a_breq; i++) begin
      n++;
      tick();
    end
    check("timeout_req_cycles", 64'(n), 64'(5));
    check("timeout_done", 64'(a_done), 64'(1));
    check("timeout_buserr", 64'(a_exb), 64'(1));
    a_req = 1'b0;
    a_back = 1'b1; a_brd = 32'h12345678;
    tick();
    a_back = 1'b0;
    check("late_ack_done", 64'(a_done), 64'(0));
    check("late_ack_bus_req", 64'(a_breq), 64'(0));

    // bus_err together with bus_ack reports an error
    access32("err_ack", 1'b0, 2'b10, 1'b0, 32'h5000, 32'h0, 32'hCAFEF00D, 0, 1'b1, 4'hF, 32'h0, 32'h0);

    // Flush during BUSY: transfer completes, no done, unit returns to IDLE
    a_req = 1'b1; a_we = 1'b0; a_w = 2'b10; a_addr = 32'h6000;
    tick();
    a_flush = 1'b1;
    #1;
    check("flush_stall", 64'(a_stall), 64'(0));
    tick();
    a_flush = 1'b0; a_req = 1'b0;
    check("flush_bus_req_held", 64'(a_breq), 64'(1));
    tick();
    a_back = 1'b1; a_brd = 32'h55555555;
    tick();
    a_back = 1'b0;
    check("flush_no_done", 64'(a_done), 64'(0));
    check("flush_idle", 64'(a_breq), 64'(0));
    access32("after_flush", 1'b0, 2'b00, 1'b0, 32'h2000, 32'h0, 32'h80112233, 0, 1'b0, 4'h1, 32'h0, 32'h00000033);

    // 64-bit unit
    load64("ld64", 2'b11, 1'b0, 32'h8, 64'h0123456789ABCDEF, 32'h8, 8'hFF, 64'h0123456789ABCDEF);
    load64("lw64", 2'b10, 1'b1, 32'hC, 64'h8765432100000000, 32'h8, 8'hF0, 64'hFFFFFFFF87654321);

    // Reset in BUSY drops bus_req at once
    a_req = 1'b1; a_we = 1'b0; a_w = 2'b10; a_addr = 32'h7000;
    tick();
    check("rst_busy_pre", 64'(a_breq), 64'(1));
    reset = 1'b0;
    #1;
    check("rst_busy_bus_req", 64'(a_breq), 64'(0));
    check("rst_busy_bus_be", 64'(a_bbe), 64'(0));
    a_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rst_busy_done", 64'(a_done), 64'(0));

    check("sb_drained", 64'(sb32.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
